// File: rtl/fmul_share_sched_if.sv
// Requester-side bundle of the shared FMUL32 scheduler: per-requester operand
// handshake plus the routed response strobe, data and flag.
interface fmul_share_sched_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_op1;
  logic [N*32-1:0] req_op2;
  logic [N*2-1:0]  req_opc;
  logic [N*2-1:0]  req_rmode;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic            resp_flag;

  // Requesting engines drive operands and consume responses.
  modport master (
    output req_valid, req_op1, req_op2, req_opc, req_rmode,
    input  req_ready, resp_valid, resp_data, resp_flag
  );

  // The scheduler grants requests and returns routed results.
  modport slave (
    input  req_valid, req_op1, req_op2, req_opc, req_rmode,
    output req_ready, resp_valid, resp_data, resp_flag
  );
endinterface

// File: rtl/fmul_share_sched.sv
// Round-robin sharing of one pipelined FMUL32 among N requesters; a {vld,id}
// tag rides alongside each op so its result is routed back to the issuer.
module fmul_share_sched #(
  parameter int N   = 4,
  parameter int LAT = 3,
  parameter int IDW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  fmul_share_sched_if.slave   rq,
  output logic [31:0]         fmul_op1,
  output logic [31:0]         fmul_op2,
  output logic [1:0]          fmul_opc,
  output logic [1:0]          fmul_rmode,
  input  logic [31:0]         fmul_result,
  input  logic                fmul_val,
  output logic                busy,
  output logic                drain_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;

  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic           issue;
  int             scan_idx;
  logic           scan_bit;

  logic [31:0]    op1_sel;
  logic [31:0]    op2_sel;
  logic [1:0]     opc_sel;
  logic [1:0]     rmode_sel;

  // Index 0 is the tag of the op held in the FMUL input register; index LAT
  // is the tag whose result is on fmul_result this cycle.
  logic           vld_p [LAT+1];
  logic [IDW-1:0] id_p  [LAT+1];

  // Round-robin scan starting at ptr, wrapping N-1 -> 0; first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    scan_bit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan_idx = (int'(ptr) + k) % N;
      scan_bit = 1'(rq.req_valid >> scan_idx);
      if (!grant_vld && scan_bit) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(scan_idx);
      end
    end
  end

  assign issue        = (state == RUN) && en && grant_vld;
  assign rq.req_ready = issue ? (N'(1) << grant_id) : '0;

  always_comb begin
    op1_sel   = 32'(rq.req_op1   >> (32 * int'(grant_id)));
    op2_sel   = 32'(rq.req_op2   >> (32 * int'(grant_id)));
    opc_sel   = 2'(rq.req_opc    >> (2 * int'(grant_id)));
    rmode_sel = 2'(rq.req_rmode  >> (2 * int'(grant_id)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= IDW'((int'(grant_id) + 1) % N);
    end
  end

  // ---- stage p0: FMUL input register, loaded only on issue so idle cycles
  // leave the multiplier inputs quiet ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmul_op1   <= '0;
      fmul_op2   <= '0;
      fmul_opc   <= '0;
      fmul_rmode <= '0;
    end else if (issue) begin
      fmul_op1   <= op1_sel;
      fmul_op2   <= op2_sel;
      fmul_opc   <= opc_sel;
      fmul_rmode <= rmode_sel;
    end
  end

  // ---- stages p0..pLAT: tag pipe shifts every cycle, no stall ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) begin
        vld_p[k] <= 1'b0;
        id_p[k]  <= '0;
      end
    end else begin
      vld_p[0] <= issue;
      id_p[0]  <= grant_id;
      for (int k = 1; k <= LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        id_p[k]  <= id_p[k-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      busy = busy | vld_p[k];
    end
  end

  // ---- response register: capture result with its tag; hold data when idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.resp_valid <= '0;
      rq.resp_data  <= '0;
      rq.resp_flag  <= 1'b0;
    end else begin
      rq.resp_valid <= vld_p[LAT] ? (N'(1) << id_p[LAT]) : '0;
      if (vld_p[LAT]) begin
        rq.resp_data <= fmul_result;
        rq.resp_flag <= fmul_val;
      end
    end
  end

  // A returning en while draining takes priority over the idle transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) state <= DRAIN;
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (!busy) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_share_sched.sv
// Bench for fmul_share_sched: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference of grants and routed responses.
module tb_fmul_share_sched;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] fmul_op1, fmul_op2, fmul_result;
  logic [1:0]  fmul_opc, fmul_rmode;
  logic        fmul_val, busy, drain_done;

  always #5 clk = ~clk;

  fmul_share_sched_if #(.N(N)) bus ();

  fmul_share_sched #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rq          (bus),
    .fmul_op1    (fmul_op1),
    .fmul_op2    (fmul_op2),
    .fmul_opc    (fmul_opc),
    .fmul_rmode  (fmul_rmode),
    .fmul_result (fmul_result),
    .fmul_val    (fmul_val),
    .busy        (busy),
    .drain_done  (drain_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // Stand-in multiplier: 1.0 is the identity, anything else just needs a
  // distinct deterministic value. val is taken from op1 bit 0.
  function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] c, input logic [1:0] r);
    if (a == 32'h3F80_0000) return b;
    return a ^ {b[15:0], b[31:16]} ^ {28'h0, c, r};
  endfunction

  logic [67:0] tap [1:LAT];
  always @(posedge clk) begin
    tap[1] <= {fmul_op1, fmul_op2, fmul_opc, fmul_rmode};
    for (int k = 2; k <= LAT; k++) tap[k] <= tap[k-1];
  end
  assign fmul_result = fake_mul(tap[LAT][67:36], tap[LAT][35:4], tap[LAT][3:2], tap[LAT][1:0]);
  assign fmul_val    = tap[LAT][36];

  // Reference: a grant is possible in a cycle only if en was also high the
  // cycle before; responses come back in issue order 2+LAT cycles later.
  typedef struct {
    int          due;
    logic [N-1:0] who;
    logic [31:0] data;
    logic        flag;
  } resp_t;

  resp_t        exp_q[$];
  resp_t        r;
  int           mptr = 0;
  int           n_drain = 0;
  int           gid, idx;
  logic         en_prev = 1'b0;
  logic         exp_busy;
  logic [N-1:0] exp_ready;
  logic [31:0]  last_op1 = '0, last_op2 = '0;
  logic [1:0]   last_opc = '0, last_rm = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_data", bus.resp_data, 0);
      chk("rst_resp_flag", 32'(bus.resp_flag), 0);
      chk("rst_fmul_op1", fmul_op1, 0);
      chk("rst_fmul_op2", fmul_op2, 0);
      chk("rst_fmul_ctl", {28'h0, fmul_opc, fmul_rmode}, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_drain_done", 32'(drain_done), 0);
      exp_q.delete();
      mptr = 0; en_prev = 1'b0;
      last_op1 = '0; last_op2 = '0; last_opc = '0; last_rm = '0;
    end else begin
      gid = -1;
      exp_ready = '0;
      if (en_prev && en) begin
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (gid < 0 && bus.req_valid[idx]) gid = idx;
        end
      end
      if (gid >= 0) exp_ready[gid] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("fmul_op1", fmul_op1, last_op1);
      chk("fmul_op2", fmul_op2, last_op2);
      chk("fmul_ctl", {28'h0, fmul_opc, fmul_rmode}, {28'h0, last_opc, last_rm});

      exp_busy = 1'b0;
      foreach (exp_q[i]) if (cyc >= exp_q[i].due - 1 - LAT && cyc <= exp_q[i].due - 1) exp_busy = 1'b1;
      chk("busy", 32'(busy), 32'(exp_busy));

      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        chk("resp_valid", 32'(bus.resp_valid), 32'(r.who));
        chk("resp_data", bus.resp_data, r.data);
        chk("resp_flag", 32'(bus.resp_flag), 32'(r.flag));
      end else begin
        chk("resp_idle", 32'(bus.resp_valid), 0);
      end
      if (drain_done) n_drain++;

      if (gid >= 0) begin
        last_op1 = bus.req_op1[32*gid +: 32];
        last_op2 = bus.req_op2[32*gid +: 32];
        last_opc = bus.req_opc[2*gid +: 2];
        last_rm  = bus.req_rmode[2*gid +: 2];
        r.due  = cyc + 2 + LAT;
        r.who  = exp_ready;
        r.data = fake_mul(last_op1, last_op2, last_opc, last_rm);
        r.flag = last_op1[0];
        exp_q.push_back(r);
        mptr = (gid + 1) % N;
      end
      en_prev = en;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c, input logic [1:0] rm);
    bus.req_op1[32*i +: 32] = a;
    bus.req_op2[32*i +: 32] = b;
    bus.req_opc[2*i +: 2]   = c;
    bus.req_rmode[2*i +: 2] = rm;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1);
  end

  int drain_before;
  int seen;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    bus.req_valid = '0;
    bus.req_op1 = '0; bus.req_op2 = '0; bus.req_opc = '0; bus.req_rmode = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op from requester 0
    en = 1'b1;
    step();
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 2'd0, 2'd0);
    bus.req_valid = 4'b0001;
    @(negedge clk) chk("single_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    @(negedge clk) chk("single_fmul_op1", fmul_op1, 32'h3F80_0000);
    repeat (LAT + 1) @(negedge clk);
    chk("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("single_resp_data", bus.resp_data, 32'h4000_0000);
    repeat (LAT + 3) step();

    // Fairness from ptr=0 (one grant to requester 3 brings ptr back to 0)
    for (int i = 0; i < N; i++) set_req(i, 32'h4100_0000 + 32'(i << 4), 32'h4040_0000 + 32'(i), 2'(i), 2'(3 - i));
    bus.req_valid = 4'b1000;
    @(negedge clk) chk("pre_fair_ready", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) chk("fair_grant", 32'(bus.req_ready), 32'h1 << (k % 4));
      step();
    end
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Wrap/skip: move ptr to 3, then 0101 grants 0 then 2, leaving ptr at 3
    bus.req_valid = 4'b0100;
    @(negedge clk) chk("wrap_pre", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = 4'b0101;
    @(negedge clk) chk("wrap_first", 32'(bus.req_ready), 32'h1);
    step();
    @(negedge clk) chk("wrap_second", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = 4'b1111;
    @(negedge clk) chk("wrap_ptr3", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Flag routing: only requester 2's op produces fmul_val=1
    for (int i = 0; i < N; i++) set_req(i, 32'h4040_0000 + 32'(i << 8) + 32'(i == 2), 32'h3FC0_0000 + 32'(i), 2'd1, 2'd2);
    bus.req_valid = 4'b1111;
    repeat (4) step();
    bus.req_valid = '0;
    seen = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) begin
        seen++;
        chk("flag_route", 32'(bus.resp_flag), 32'(bus.resp_valid == 4'b0100));
      end
    end
    chk("flag_resp_count", 32'(seen), 32'd4);
    repeat (2) step();

    // Drain: three ops, then en falls with requests still pending
    drain_before = n_drain;
    bus.req_valid = 4'b0111;
    repeat (3) step();
    en = 1'b0;
    repeat (LAT + 8) step();
    chk("drain_pulse_count", 32'(n_drain - drain_before), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);
    bus.req_valid = 4'b0001;
    en = 1'b1;
    @(negedge clk) chk("idle_no_grant", 32'(bus.req_ready), 32'h0);
    step();
    @(negedge clk) chk("after_idle_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Reset with two ops in flight
    bus.req_valid = 4'b0011;
    repeat (2) step();
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fmul_op1", fmul_op1, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (LAT + 4) step();
    bus.req_valid = 4'b1111;
    @(negedge clk) chk("midrst_ptr0", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Random traffic with occasional en drops
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      step();
    end

    bus.req_valid = '0;
    en = 1'b0;
    repeat (LAT + 8) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
